cirno_sequencer: RTL
====================

# cirno_sequencer

Control sequencer that consumes the 9-bit instruction word presented combinationally by the CPU's fetch unit and drives that unit's control inputs (init, branch, branchi, fetch_unit_en, target, immediate). It also registers decoded fields for the datapath, handles stall and halt, and counts retired instructions. It is the receiving end of the fetch interface and sits between fetch and the register file/ALU.

## Interface
- START_WIDTH, 9: width of start_address and of the fetch PC.
- CNT_WIDTH, 16: width of retired_count.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; begins execution from IDLE or HALT.
- start_address  in  9  PC loaded by the fetch unit during INIT.
- inst  in  9  instruction from the fetch unit, valid for the current PC in the same cycle.
- busy  in  1  datapath not ready; stalls fetch and retire.
- zero_flag  in  1  ALU zero flag, used by bz.
- reg_rdata  in  8  register-file read data for register rs.
- reg_raddr  out  2  equals inst[1:0], combinational.
- init, branch, branchi, fetch_unit_en  out  1 each  fetch controls, combinational (Mealy).
- target  out  8  equals reg_rdata.
- immediate  out  6  equals inst[5:0].
- op_valid  out  1  registered; pulses once per retired non-system instruction.
- opcode  out  3, rd  out  2, rs  out  2, imm4  out  4  registered decode fields.
- halted  out  1  registered; high in HALT.
- retired_count  out  CNT_WIDTH  registered; number of retired instructions.

## Operation
- Encoding: opcode=inst[8:6], rd=inst[5:4], imm4=inst[3:0], rs=inst[1:0].
- Opcodes:
  - 000 system: inst[5:0]=000001 is halt; any other value is nop.
  - 001 add, 100 movil, 101 movih, 010/011 reserved ALU ops: datapath only.
  - 110 br: absolute branch to reg_rdata.
  - 111 bz: pc+inst[5:0] if zero_flag=1, else pc+1.
- States: IDLE, INIT, EXEC, HALT. Reset enters IDLE.
  - IDLE: all fetch controls 0. start=1 -> INIT.
  - INIT (exactly one cycle): init=1, fetch_unit_en=1 -> EXEC.
  - EXEC, busy=1: fetch_unit_en=0, no retire, no register update.
  - EXEC, busy=0:
    - halt: fetch_unit_en=0; retires; -> HALT.
    - br: fetch_unit_en=1, branch=1; retires.
    - bz taken: fetch_unit_en=1, branchi=1; retires. Not taken: fetch_unit_en=1 only.
    - other: fetch_unit_en=1; retires.
  - HALT: controls 0, halted=1. start=1 -> INIT. start in EXEC is ignored.
- branch and branchi are never both high. init is high only in INIT.
- Retire updates:
  - retired_count increments by 1 and wraps at 2^CNT_WIDTH-1 -> 0.
  - opcode, rd, rs and imm4 are captured.
  - op_valid=1 for the following cycle only if opcode is not 000; otherwise op_valid=0.
- Reserved opcodes retire as datapath ops. The sequencer does not flag them.

## Timing
- Reset values: all registered outputs 0. State IDLE; therefore all Mealy outputs 0.
- Fetch controls are combinational from state, inst, busy, zero_flag and reg_rdata, and are sampled by the fetch unit on the same rising edge.
- Decode fields have 1-cycle latency after the retiring edge. op_valid is high for exactly 1 cycle per retire.
- Throughput: 1 instruction per cycle while busy=0.
- start takes 2 cycles to first retire: IDLE -> INIT edge, then INIT -> EXEC edge.
- halted rises the cycle after halt retires.
- Asynchronous rst_n assertion at any point forces IDLE and zeroes outputs immediately; the counter is cleared.
- busy during INIT is ignored.

## Test plan
- Reset, start=1, start_address=0: init=1 for one cycle, then fetch_unit_en=1. Stream movih/movil/add/halt from addresses 0-5 -> retired_count=6, halted=1, op_valid pulsed 5 times.
- busy=1 for 3 cycles mid-stream on add: fetch_unit_en=0 for 3 cycles, count frozen, add retires once after release.
- bz with inst=111000100:
  - zero_flag=1: branchi=1, immediate=4.
  - zero_flag=0: branchi=0, fetch_unit_en=1.
- br with reg_rdata=8'h20: branch=1, target=8'h20, branchi=0.
- In HALT, pulse start: INIT then EXEC, halted drops to 0. Count continues without reset.
- Assert rst_n=0 mid-EXEC between edges: outputs 0 immediately, retired_count=0, stays IDLE until start.

Source files
------------

// File: rtl/cirno_sequencer.sv
// cirno_sequencer: control sequencer between the fetch unit and the datapath.
// Consumes the 9-bit instruction for the current PC and drives the fetch
// controls combinationally. Registers decoded fields for the datapath, handles
// stall (busy) and halt, and counts retired instructions.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            level; begins execution from IDLE or HALT
//   start_address    PC the fetch unit loads during INIT (not used here)
//   inst             instruction word for the current PC
//   busy             datapath stall; blocks fetch advance and retire
//   zero_flag        ALU zero flag, used by bz
//   reg_rdata        register-file read data for rs
//   reg_raddr        register-file read address (inst[1:0])
//   init, branch, branchi, fetch_unit_en   fetch controls (Mealy)
//   target           branch target for br (reg_rdata)
//   immediate        bz offset (inst[5:0])
//   op_valid         one-cycle pulse per retired non-system instruction
//   opcode, rd, rs, imm4   registered decode fields of the last retire
//   halted           high while in HALT
//   retired_count    number of retired instructions (wraps)
module cirno_sequencer #(
    parameter int unsigned START_WIDTH = 9,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [START_WIDTH-1:0] start_address,
    input  logic [8:0]             inst,
    input  logic                   busy,
    input  logic                   zero_flag,
    input  logic [7:0]             reg_rdata,
    output logic [1:0]             reg_raddr,
    output logic                   init,
    output logic                   branch,
    output logic                   branchi,
    output logic                   fetch_unit_en,
    output logic [7:0]             target,
    output logic [5:0]             immediate,
    output logic                   op_valid,
    output logic [2:0]             opcode,
    output logic [1:0]             rd,
    output logic [1:0]             rs,
    output logic [3:0]             imm4,
    output logic                   halted,
    output logic [CNT_WIDTH-1:0]   retired_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        EXEC = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [2:0] OP_SYS = 3'b000;
    localparam logic [2:0] OP_BR  = 3'b110;
    localparam logic [2:0] OP_BZ  = 3'b111;

    state_t               state_q, state_d;
    logic                 op_valid_q;
    logic [2:0]           opcode_q;
    logic [1:0]           rd_q, rs_q;
    logic [3:0]           imm4_q;
    logic                 halted_q;
    logic [CNT_WIDTH-1:0] count_q;

    logic [2:0] inst_op;
    logic       is_halt;
    logic       retire;

    // The fetch unit owns the PC; start_address only passes by this block.
    logic unused_start_address;
    assign unused_start_address = ^start_address;

    assign inst_op   = inst[8:6];
    assign is_halt   = (inst_op == OP_SYS) && (inst[5:0] == 6'b000001);
    assign reg_raddr = inst[1:0];
    assign target    = reg_rdata;
    assign immediate = inst[5:0];

    // Mealy fetch controls and next state
    always_comb begin
        init          = 1'b0;
        branch        = 1'b0;
        branchi       = 1'b0;
        fetch_unit_en = 1'b0;
        retire        = 1'b0;
        state_d       = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = INIT;
            end
            INIT: begin
                init          = 1'b1;
                fetch_unit_en = 1'b1;
                state_d       = EXEC;
            end
            EXEC: begin
                if (!busy) begin
                    retire = 1'b1;
                    if (is_halt) begin
                        state_d = HALT;
                    end else begin
                        fetch_unit_en = 1'b1;
                        branch        = (inst_op == OP_BR);
                        branchi       = (inst_op == OP_BZ) && zero_flag;
                    end
                end
            end
            HALT: begin
                if (start) state_d = INIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_valid_q <= 1'b0;
            opcode_q   <= '0;
            rd_q       <= '0;
            rs_q       <= '0;
            imm4_q     <= '0;
            halted_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            halted_q   <= (state_d == HALT);
            op_valid_q <= retire && (inst_op != OP_SYS);
            if (retire) begin
                count_q  <= count_q + 1'b1;
                opcode_q <= inst_op;
                rd_q     <= inst[5:4];
                rs_q     <= inst[1:0];
                imm4_q   <= inst[3:0];
            end
        end
    end

    assign op_valid      = op_valid_q;
    assign opcode        = opcode_q;
    assign rd            = rd_q;
    assign rs            = rs_q;
    assign imm4          = imm4_q;
    assign halted        = halted_q;
    assign retired_count = count_q;

endmodule
